// File: rtl/guess_input_pkg.sv
// -----------------------------------------------------------------------------
// guess_input_pkg
// Shared types and constants for the guess_input block:
//   NUM_HOLES    - number of mole buttons (fixed at 8 so a guess fits 3 bits)
//   GUESS_W      - width of the encoded guess index
//   state_e      - press-qualification FSM states
//   onehot_to_idx- encodes a one-hot button vector into its bit index
// -----------------------------------------------------------------------------
package guess_input_pkg;

    localparam int NUM_HOLES = 8;
    localparam int GUESS_W   = 3;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        EVAL         = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_e;

    // Encodes a one-hot vector into its index. A zero vector encodes to 0;
    // callers only use it on vectors known to be one-hot.
    function automatic logic [GUESS_W-1:0] onehot_to_idx(input logic [NUM_HOLES-1:0] oh);
        logic [GUESS_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (oh[i]) begin
                idx = idx | GUESS_W'(i);
            end
        end
        return idx;
    endfunction

endpackage : guess_input_pkg

// File: rtl/guess_input_if.sv
// -----------------------------------------------------------------------------
// guess_input_if
// Output bundle from guess_input to the game top level.
//   o_user_guess   - index of the last accepted press, holds between presses
//   o_eval_now     - one-cycle pulse: o_user_guess is valid and new
//   o_restart_game - one-cycle restart pulse
//   o_btn_stable   - debounced mole-button levels (LED/debug path)
// Modports: master (driven by guess_input), slave (consumer).
// -----------------------------------------------------------------------------
interface guess_input_if;
    import guess_input_pkg::*;

    logic [GUESS_W-1:0]   o_user_guess;
    logic                 o_eval_now;
    logic                 o_restart_game;
    logic [NUM_HOLES-1:0] o_btn_stable;

    modport master (
        output o_user_guess,
        output o_eval_now,
        output o_restart_game,
        output o_btn_stable
    );

    modport slave (
        input o_user_guess,
        input o_eval_now,
        input o_restart_game,
        input o_btn_stable
    );

endinterface : guess_input_if

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One raw asynchronous button -> 2-flop synchroniser -> debounce counter ->
// debounced level plus a one-cycle rise pulse.
// Parameter: DEBOUNCE_CYCLES - consecutive cycles the synchronised value must
//            differ from the debounced level before the level flips.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous, active-high reset
//   i_raw   in   raw asynchronous button, active-high
//   o_level out  debounced level (registered)
//   o_rise  out  debounced level is 1 now and was 0 on the previous cycle
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    // Sized to hold DEBOUNCE_CYCLES; the counter clears on reaching it, so it
    // never wraps.
    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any cycle where the synchronised input agrees with the debounced level
    // restarts the count, so only an unbroken run of disagreement flips it.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= i_raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = level_q & ~level_prev_q;

endmodule : btn_debounce

// File: rtl/guess_input.sv
// -----------------------------------------------------------------------------
// guess_input
// Upstream input stage of the whack-a-mole game. Synchronises, debounces and
// edge-detects the eight mole buttons and the restart button, then qualifies
// presses so each physical press yields at most one evaluation.
// Parameter: DEBOUNCE_CYCLES (default 500000 = 5 ms at 100 MHz).
// Hole count is fixed at NUM_HOLES = 8 (guess_input_pkg) since the guess is 3 bits.
// Optional feature macro: GUESS_INPUT_PRIORITY_EN
//   defined   - simultaneous rises in IDLE are accepted, lowest index wins
//   undefined - simultaneous rises are rejected (no pulse)
// Ports:
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   i_btn         in   raw mole buttons, bit k = hole k, active-high
//   i_restart_btn in   raw restart button, active-high
//   bus           guess_input_if.master: o_user_guess, o_eval_now,
//                 o_restart_game, o_btn_stable
// -----------------------------------------------------------------------------
module guess_input
    import guess_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_HOLES-1:0] i_btn,
    input  logic                 i_restart_btn,
    guess_input_if.master        bus
);

    logic [NUM_HOLES-1:0] btn_level;
    logic [NUM_HOLES-1:0] btn_rise;
    logic                 restart_level_unused;
    logic                 restart_rise;

    for (genvar k = 0; k < NUM_HOLES; k++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (i_btn[k]),
            .o_level (btn_level[k]),
            .o_rise  (btn_rise[k])
        );
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_restart_debounce (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (i_restart_btn),
        .o_level (restart_level_unused),
        .o_rise  (restart_rise)
    );

    // A rising button's own level is already 1, so mask it out; a button
    // released this cycle is already 0 and does not count as held.
    logic others_held;
    logic single_rise;
    assign others_held = |(btn_level & ~btn_rise);
    assign single_rise = ((btn_rise & (btn_rise - NUM_HOLES'(1))) == '0);

`ifdef GUESS_INPUT_PRIORITY_EN
    // Isolates the lowest set bit (two's-complement trick).
    logic [NUM_HOLES-1:0] lowest_rise;
    assign lowest_rise = btn_rise & (~btn_rise + NUM_HOLES'(1));
`endif

    state_e             state_q;
    logic [GUESS_W-1:0] guess_q;
    logic               eval_q;
    logic               restart_q;

    // Outputs are registered alongside the state, so o_eval_now is high exactly
    // while the FSM sits in EVAL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            guess_q   <= '0;
            eval_q    <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            eval_q    <= 1'b0;
            restart_q <= 1'b0;
            if (restart_rise) begin
                // Restart wins over any mole rise this cycle; that press is
                // discarded and must be released before the next one counts.
                restart_q <= 1'b1;
                state_q   <= WAIT_RELEASE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (|btn_rise) begin
                            if (others_held) begin
                                state_q <= WAIT_RELEASE;
                            end else if (single_rise) begin
                                state_q <= EVAL;
                                guess_q <= onehot_to_idx(btn_rise);
                                eval_q  <= 1'b1;
                            end else begin
`ifdef GUESS_INPUT_PRIORITY_EN
                                state_q <= EVAL;
                                guess_q <= onehot_to_idx(lowest_rise);
                                eval_q  <= 1'b1;
`else
                                state_q <= WAIT_RELEASE;
`endif
                            end
                        end
                    end
                    EVAL: begin
                        state_q <= WAIT_RELEASE;
                    end
                    WAIT_RELEASE: begin
                        if (btn_level == '0) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_user_guess   = guess_q;
    assign bus.o_eval_now     = eval_q;
    assign bus.o_restart_game = restart_q;
    assign bus.o_btn_stable   = btn_level;

endmodule : guess_input
